// File: rtl/bin_avg_engine.sv
// Per-bin power-of-two averaging engine for streamed FFT frames.
// Samples arrive bin 0..BINS-1 per frame; after 2^n frames every bin's
// accumulated sum is shifted right by n and registered on out_data.

// One accumulator lane: holds the running sum of one bin and presents the
// averaged value of the sum that results from the current cycle's write.
module bin_avg_lane #(
  parameter int N             = 16,
  parameter int MAX_LOG2_AVGS = 7,
  parameter int SIGNED        = 0,
  parameter int AW            = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic          first,
  input  logic [N-1:0]  din,
  input  logic [AW-1:0] n,
  output logic [N-1:0]  avg
);
  localparam int SUM_WIDTH = N + MAX_LOG2_AVGS;

  logic [SUM_WIDTH-1:0] sum_q, ext, sum_nx, fin;

  generate
    if (SIGNED != 0) begin : g_sext
      assign ext = {{MAX_LOG2_AVGS{din[N-1]}}, din};
      assign avg = N'($signed(fin) >>> n);
    end else begin : g_zext
      assign ext = {{MAX_LOG2_AVGS{1'b0}}, din};
      assign avg = N'(fin >> n);
    end
  endgenerate

  // Frame 0 overwrites, later frames add; fin includes the sample being written now
  always_comb begin
    sum_nx = first ? ext : sum_q + ext;
    fin    = we ? sum_nx : sum_q;
  end

  // Accumulator needs no reset: frame 0 always overwrites it
  always_ff @(posedge clk) begin
    if (we) sum_q <= sum_nx;
  end
endmodule

module bin_avg_engine #(
  parameter int N             = 16,
  parameter int BINS          = 4,
  parameter int MAX_LOG2_AVGS = 7,
  parameter int SIGNED        = 0
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [N-1:0]           in_data,
  input  logic [$clog2(MAX_LOG2_AVGS+1)-1:0] n_avgs_in,
  output logic [BINS-1:0][N-1:0] out_data,
  output logic                   out_valid,
  output logic                   frame_err,
  output logic [$clog2(MAX_LOG2_AVGS+1)-1:0] n_avgs_active,
  output logic                   busy
);
  localparam int SUM_WIDTH = N + MAX_LOG2_AVGS;
  localparam int AW        = $clog2(MAX_LOG2_AVGS + 1);
  localparam int BW        = $clog2(BINS);
  localparam int FW        = (MAX_LOG2_AVGS > 0) ? MAX_LOG2_AVGS : 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state_q, state_nx;
  logic [BW-1:0]     b_q, cur_b;
  logic [FW-1:0]     f_q, cur_f, f_last;
  logic [AW-1:0]     n_clamp, cur_n;
  logic              accept, restart, proc, done, misalign, period_start;
  logic [BINS-1:0][N-1:0] lane_avg;

  // Accept/restart decode; the effective bin/frame/n for the sample this cycle
  always_comb begin
    accept   = in_valid & ~clear;
    misalign = accept & in_sof & (state_q == ACCUM) & (b_q != '0);
    restart  = accept & in_sof & ((state_q == IDLE) | (b_q != '0));
    proc     = accept & ((state_q == ACCUM) | in_sof);
    cur_b    = restart ? '0 : b_q;
    cur_f    = restart ? '0 : f_q;
    n_clamp  = (n_avgs_in > AW'(MAX_LOG2_AVGS)) ? AW'(MAX_LOG2_AVGS) : n_avgs_in;
    period_start = (cur_b == '0) & (cur_f == '0);
    cur_n    = period_start ? n_clamp : n_avgs_active;
    f_last   = FW'((32'd1 << cur_n) - 32'd1);
    done     = proc & (cur_b == BW'(BINS - 1)) & (cur_f == f_last);
  end

  // Next-state logic: clear wins, any accepted sample keeps us accumulating
  always_comb begin
    state_nx = state_q;
    busy     = (state_q == ACCUM);
    if (clear)     state_nx = IDLE;
    else if (proc) state_nx = ACCUM;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_nx;
  end

  // Bin/frame counters, latched n and output registers
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      b_q           <= '0;
      f_q           <= '0;
      n_avgs_active <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      out_valid <= done;
      frame_err <= misalign;
      if (clear) begin
        b_q <= '0;
        f_q <= '0;
      end else if (proc) begin
        if (period_start) n_avgs_active <= n_clamp;
        if (done) begin
          b_q      <= '0;
          f_q      <= '0;
          out_data <= lane_avg;
        end else if (cur_b == BW'(BINS - 1)) begin
          b_q <= '0;
          f_q <= cur_f + FW'(1);
        end else begin
          b_q <= cur_b + BW'(1);
          f_q <= cur_f;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < BINS; i++) begin : g_lane
      bin_avg_lane #(
        .N(N), .MAX_LOG2_AVGS(MAX_LOG2_AVGS), .SIGNED(SIGNED), .AW(AW)
      ) u_lane (
        .clk   (clk),
        .we    (proc & (cur_b == BW'(i))),
        .first (cur_f == '0),
        .din   (in_data),
        .n     (cur_n),
        .avg   (lane_avg[i])
      );
    end
  endgenerate

  // Sum width is implied by the lane parameters; kept here for readers
  localparam int SUM_W_CHECK = SUM_WIDTH;
endmodule

// File: doc/bin_avg_engine.md
BIN_AVG_ENGINE -- requirements
Module: bin_avg_engine

Interface
REQ-001 SHALL have parameter N, default 16: sample and output width in bits.
REQ-002 SHALL have parameter BINS, default 4: bins per FFT frame, at least 2.
REQ-003 SHALL have parameter MAX_LOG2_AVGS, default 7: largest runtime log2 average count.
REQ-004 SHALL have parameter SIGNED, default 0: 1 gives two's-complement arithmetic, 0 gives unsigned.
REQ-005 SHALL derive localparam SUM_WIDTH = N+MAX_LOG2_AVGS and AW = $clog2(MAX_LOG2_AVGS+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port areset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port clear, input, 1 bit: synchronous soft clear, active-high.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data and in_sof are valid this cycle.
REQ-010 SHALL have port in_sof, input, 1 bit: current sample is bin 0 of a frame.
REQ-011 SHALL have port in_data, input, N bits: bin sample.
REQ-012 SHALL have port n_avgs_in, input, AW bits: requested log2 average count.
REQ-013 SHALL have port out_data, output, [BINS][N] bits: averaged bins.
REQ-014 SHALL have port out_valid, output, 1 bit: one-cycle pulse when out_data updates.
REQ-015 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a misaligned in_sof.
REQ-016 SHALL have port n_avgs_active, output, AW bits: log2 count latched for the current period.
REQ-017 SHALL have port busy, output, 1 bit: high while in state ACCUM.

Function
REQ-018 SHALL implement FSM states IDLE and ACCUM.
REQ-019 In IDLE, SHALL drop samples without in_sof; on in_valid&in_sof SHALL enter ACCUM and process that sample as bin 0, frame 0.
REQ-020 SHALL keep bin counter b (0..BINS-1) and frame counter f, both advancing only on accepted samples; b wraps BINS-1->0 and f increments on the wrap.
REQ-021 SHALL hold one SUM_WIDTH accumulator per bin; a frame-0 sample overwrites sum[b], any later frame adds into sum[b] (sign- or zero-extended per SIGNED).
REQ-022 At the frame-0 bin-0 sample, SHALL latch n = min(n_avgs_in, MAX_LOG2_AVGS) into n_avgs_active; changes to n_avgs_in mid-period SHALL be ignored.
REQ-023 On the sample with b=BINS-1 and f=2^n-1, SHALL register out_data[i] = (final sum[i]) >> n (arithmetic shift if SIGNED), low N bits, for all i; this includes the current sample for bin BINS-1.
REQ-024 SHALL pulse out_valid in the cycle after the completing sample (latency 1) and hold out_data until the next update.
REQ-025 SHALL round by truncation toward negative infinity, with no saturation; with n=0, out_data SHALL equal the last frame's inputs.
REQ-026 After completion, f SHALL return to 0 so the next sample starts a new period without a gap; back-to-back in_valid at full rate SHALL be supported.
REQ-027 In ACCUM, on in_valid&in_sof with b≠0: SHALL pulse frame_err next cycle, discard the partial period, treat the sample as bin 0, frame 0, and relatch n.
REQ-028 In ACCUM, in_sof with b=0 SHALL be normal; a missing in_sof at b=0 SHALL be accepted without error.
REQ-029 clear SHALL force IDLE and zero b and f, leaving out_data unchanged and not pulsing out_valid; clear SHALL win over a simultaneous in_valid.

Reset
REQ-030 While areset_n=0 at a clk edge: SHALL set state IDLE, b=f=0, out_data=0, out_valid=0, frame_err=0, n_avgs_active=0, busy=0; accumulators need no reset.
REQ-031 Reset mid-period SHALL discard the partial sums; no out_valid SHALL be produced until a full new period completes after an in_sof.

Verification
REQ-032 SHALL check: BINS=4, N=16, n_avgs_in=2, four frames of bins 10,20,30,40 with in_sof on bin 0 -> one out_valid pulse one cycle after the 16th sample, out_data={10,20,30,40}.
REQ-033 SHALL check: SIGNED=1, n=2, bin0 values -3,-3,-3,-2 -> out_data[0]=-3; unsigned bin0 values 1,1,1,2 -> 1.
REQ-034 SHALL check: n=0, frame 5,6,7,8 -> out_valid after every frame, out_data={5,6,7,8}.
REQ-035 SHALL check: in_sof at b=2 mid-period -> frame_err pulse, no out_valid for the old period, correct average after a full new period.
REQ-036 SHALL check: n_avgs_in changed 2->0 mid-period -> current period still uses 4 frames and n_avgs_active=2 until the next period.
REQ-037 SHALL check: areset_n low mid-period, then non-sof samples -> samples dropped, busy=0, out_data=0, no out_valid.
